// File: rtl/timer_dev.sv
// Memory-mapped programmable down-counter with one-shot and auto-reload modes.
// Register map by word offset: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only), 3 reserved.
module timer_dev #(
    parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state, state_nx;
    logic        en, en_nx;
    logic        im, im_nx;
    logic [1:0]  mode, mode_nx;
    logic [31:0] preset, preset_nx;
    logic [31:0] count, count_nx;
    logic        irq_flag, flag_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            en       <= 1'b0;
            im       <= 1'b0;
            mode     <= 2'd0;
            preset   <= RESET_PRESET;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nx;
            en       <= en_nx;
            im       <= im_nx;
            mode     <= mode_nx;
            preset   <= preset_nx;
            count    <= count_nx;
            irq_flag <= flag_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        en_nx     = en;
        im_nx     = im;
        mode_nx   = mode;
        preset_nx = preset;
        count_nx  = count;
        flag_nx   = irq_flag;

        case (state)
            S_IDLE: if (en) state_nx = S_LOAD;
            S_LOAD: begin
                count_nx = preset;
                state_nx = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_nx = S_IDLE;
                end else if (count == '0) begin
                    state_nx = S_INT;
                    flag_nx  = 1'b1;
                end else begin
                    count_nx = count - 32'd1;
                end
            end
            S_INT: begin
                // MODE 2/3 fall through to one-shot behaviour
                if (mode == 2'd1) begin
                    state_nx = S_LOAD;
                    flag_nx  = 1'b0;
                end else begin
                    state_nx = S_IDLE;
                    en_nx    = 1'b0;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // CPU writes land last so they override the FSM's EN clear and flag updates
        if (we) begin
            case (addr)
                A_CTRL: begin
                    en_nx   = din[0];
                    mode_nx = din[2:1];
                    im_nx   = din[3];
                    flag_nx = 1'b0;
                end
                A_PRESET: preset_nx = din;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (addr)
            A_CTRL:   dout = {28'd0, im, mode, en};
            A_PRESET: dout = preset;
            A_COUNT:  dout = count;
            default:  dout = '0;
        endcase
    end

    assign irq = irq_flag & im;

endmodule

// File: tb/tb_timer_dev.sv
// Directed and randomized checks of timer_dev against a closed-form timeline model
// (expected COUNT/flag/EN derived from edges elapsed since the enabling write).
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks = 0;
    int fails  = 0;

    timer_dev #(.RESET_PRESET(32'h0000_0000)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; din = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Timeline after enabling at edge t with PRESET=n: k = edges since t.
    // COUNT=n at k=2, reaches 0 at k=n+2, flag rises at k=n+3; reload period n+3.
    task automatic expect_run(input int k, input int n, input bit reload, input logic [31:0] c_before,
                              output logic [31:0] c, output bit f, output bit e);
        int j, r;
        e = 1'b1; f = 1'b0; c = c_before;
        if (k < 2) return;
        j = k - 2;
        if (reload) begin
            r = j % (n + 3);
            c = (r <= n) ? 32'(n - r) : 32'd0;
            f = (r == n + 1);
        end else if (j <= n) begin
            c = 32'(n - j);
        end else begin
            c = 32'd0;
            f = 1'b1;
            e = (j == n + 1);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ectrl, input logic [31:0] epre,
                             input logic [31:0] ecnt, input bit eirq);
        logic [31:0] v;
        chk({tag, " irq"}, {31'd0, irq}, {31'd0, eirq});
        rd(2'd0, v); chk({tag, " ctrl"}, v, ectrl);
        rd(2'd1, v); chk({tag, " preset"}, v, epre);
        rd(2'd2, v); chk({tag, " count"}, v, ecnt);
    endtask

    initial begin : stim
        logic [31:0] v, ec;
        bit ef, ee;
        int n, md, kd, len;
        bit im, dis, reload;

        rst = 1'b0; we = 1'b0; addr = 2'd0; din = '0;

        // reset state
        do_reset();
        check_all("reset", 32'd0, 32'd0, 32'd0, 1'b0);

        // reset mid-count
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        repeat (4) tick();
        do_reset();
        check_all("rst_mid", 32'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) tick();
        check_all("rst_idle", 32'd0, 32'd0, 32'd0, 1'b0);

        // one-shot, PRESET=5, IM=1
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            tick();
            expect_run(k, 5, 1'b0, 32'd0, ec, ef, ee);
            check_all($sformatf("oneshot k%0d", k), {28'd0, 1'b1, 2'd0, ee}, 32'd5, ec, ef);
        end
        wr(2'd0, 32'h0);
        check_all("oneshot_clr", 32'd0, 32'd5, 32'd0, 1'b0);

        // auto-reload, PRESET=3: pulse every 6 cycles
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 21; k++) begin
            tick();
            expect_run(k, 3, 1'b1, 32'd0, ec, ef, ee);
            check_all($sformatf("reload k%0d", k), 32'hB, 32'd3, ec, ef);
        end

        // disable mid-count, then re-enable reloads
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        repeat (5) tick();
        rd(2'd2, v); chk("dis pre", v, 32'd7);
        wr(2'd0, 32'h8);
        for (int k = 0; k < 4; k++) begin
            check_all($sformatf("dis hold%0d", k), 32'h8, 32'd10, 32'd6, 1'b0);
            tick();
        end
        wr(2'd0, 32'h9);
        tick();
        tick();
        check_all("reen", 32'h9, 32'd10, 32'd10, 1'b0);

        // masked expiry
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("masked irq k%0d", k), {31'd0, irq}, 32'd0);
        end
        check_all("masked end", 32'd0, 32'd2, 32'd0, 1'b0);
        wr(2'd0, 32'h8);
        tick();
        check_all("masked im", 32'h8, 32'd2, 32'd0, 1'b0);

        // address map
        do_reset();
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, v); chk("ctrl_mask", v, 32'hF);
        do_reset();
        wr(2'd2, 32'h1234_5678);
        wr(2'd3, 32'hDEAD_BEEF);
        rd(2'd3, v); chk("addr3", v, 32'd0);
        check_all("ro_writes", 32'd0, 32'd0, 32'd0, 1'b0);

        // PRESET write during CNT affects only the next run
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        tick();
        tick();
        wr(2'd1, 32'd7);
        check_all("pre_cnt", 32'h1, 32'd7, 32'd3, 1'b0);
        repeat (5) tick();
        check_all("pre_idle", 32'h0, 32'd7, 32'd0, 1'b0);
        wr(2'd0, 32'h1);
        tick();
        tick();
        check_all("pre_next", 32'h1, 32'd7, 32'd7, 1'b0);

        // randomized runs, optional disable inside the first period
        for (int run = 0; run < 12; run++) begin
            n      = $urandom_range(0, 6);
            md     = $urandom_range(0, 3);
            im     = 1'($urandom_range(0, 1));
            reload = (md == 1);
            dis    = (n >= 1) && ($urandom_range(0, 1) == 1);
            kd     = dis ? $urandom_range(3, n + 2) : 0;
            len    = 2 * (n + 3) + 3;
            do_reset();
            wr(2'd1, 32'(n));
            wr(2'd0, {28'd0, im, 2'(md), 1'b1});
            for (int k = 1; k <= len; k++) begin
                if (dis && k == kd) wr(2'd0, {28'd0, im, 2'(md), 1'b0});
                else tick();
                if (dis && k >= kd) begin
                    ec = 32'(n - (kd - 2)); ef = 1'b0; ee = 1'b0;
                end else begin
                    expect_run(k, n, reload, 32'd0, ec, ef, ee);
                end
                check_all($sformatf("rnd r%0d n%0d m%0d k%0d", run, n, md, k),
                          {28'd0, im, 2'(md), ee}, 32'(n), ec, ef & im);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
